fast_cmd_encoder: RTL and testbench

- Upstream stage of fast_cmd_decoder on the test-stand side.
- Collects single-cycle fast-command request strobes into pending flags.
- Once per 8-cycle frame, selects one legal 8-bit fast-command word: 110 + 4-bit flag + 1.
- Serializes the word MSB-first at 320 MHz onto the T1 line (cmd_tx), and emits a frame-aligned 40 MHz clock plus monitoring outputs.

---
 rtl/fast_cmd_pkg.sv | 44 ++++
 rtl/fast_cmd_word_sel.sv | 63 ++++++
 rtl/fast_cmd_encoder.sv | 95 +++++++++
 tb/tb_fast_cmd_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fast_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fast_cmd_pkg
//  Brief   : Fast-command word format, flag codes and pending-vector layout.
//  Revision: 1.0  initial release
// ============================================================================
package fast_cmd_pkg;

   localparam logic [2:0] HEADER    = 3'b110;
   localparam logic [7:0] IDLE_WORD = 8'hC1;

   localparam logic [3:0] Idle                 = 4'b0000;
   localparam logic [3:0] OrbitSync            = 4'b0001;
   localparam logic [3:0] L1A_Normal           = 4'b0010;
   localparam logic [3:0] L1A_Normal_OrbitSync = 4'b0011;
   localparam logic [3:0] L1A_Full             = 4'b0100;
   localparam logic [3:0] L1A_Full_OrbitSync   = 4'b0101;
   localparam logic [3:0] OrbitCountReset      = 4'b0111;
   localparam logic [3:0] CalibReq             = 4'b1000;
   localparam logic [3:0] Calib_L1A_Normal     = 4'b1001;
   localparam logic [3:0] Calib_L1A_Full       = 4'b1010;
   localparam logic [3:0] ReSync_L1A_Full      = 4'b1011;
   localparam logic [3:0] ReSync               = 4'b1111;

   localparam int PND_ORBIT_SYNC = 0;
   localparam int PND_L1A_NORMAL = 1;
   localparam int PND_L1A_FULL   = 2;
   localparam int PND_CALIB_REQ  = 3;
   localparam int PND_CALIB_L1A  = 4;
   localparam int PND_OCR        = 5;
   localparam int PND_RESYNC     = 6;
   localparam int PND_W          = 7;

   typedef logic [PND_W-1:0] pending_t;

   function automatic logic [2:0] countOnes(input pending_t v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < PND_W; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fast_cmd_word_sel.sv
`default_nettype none
// ============================================================================
//  Module  : fast_cmd_word_sel
//  Brief   : Priority selector choosing the frame's fast-command flag.
//  Revision: 1.0  initial release
// ============================================================================
module fast_cmd_word_sel
   import fast_cmd_pkg::*;
#(
   parameter bit L1A_FULL_FIRST = 1'b0
) (
   input  pending_t   pending,
   input  logic       enable,
   output logic [3:0] flag,
   output pending_t   clrMask
);

   logic w_anyL1a;
   logic w_selFull;

   assign w_anyL1a = pending[PND_L1A_NORMAL] | pending[PND_L1A_FULL];

   always_comb begin
      flag      = Idle;
      clrMask   = '0;
      w_selFull = L1A_FULL_FIRST ? pending[PND_L1A_FULL] : ~pending[PND_L1A_NORMAL];
      if (!enable) begin
         flag = Idle;
      end else if (pending[PND_RESYNC] && pending[PND_L1A_FULL]) begin
         flag                    = ReSync_L1A_Full;
         clrMask[PND_RESYNC]     = 1'b1;
         clrMask[PND_L1A_FULL]   = 1'b1;
      end else if (pending[PND_RESYNC]) begin
         flag                    = ReSync;
         clrMask[PND_RESYNC]     = 1'b1;
      end else if (pending[PND_OCR]) begin
         flag                    = OrbitCountReset;
         clrMask[PND_OCR]        = 1'b1;
         clrMask[PND_ORBIT_SYNC] = 1'b1;
      end else if (w_anyL1a) begin
         // A calibration-qualified L1A cannot carry orbit sync; it waits a frame.
         if (pending[PND_CALIB_L1A]) begin
            flag                   = w_selFull ? Calib_L1A_Full : Calib_L1A_Normal;
            clrMask[PND_CALIB_L1A] = 1'b1;
         end else if (pending[PND_ORBIT_SYNC]) begin
            flag                    = w_selFull ? L1A_Full_OrbitSync : L1A_Normal_OrbitSync;
            clrMask[PND_ORBIT_SYNC] = 1'b1;
         end else begin
            flag = w_selFull ? L1A_Full : L1A_Normal;
         end
         clrMask[PND_L1A_FULL]   = w_selFull;
         clrMask[PND_L1A_NORMAL] = ~w_selFull;
      end else if (pending[PND_ORBIT_SYNC]) begin
         flag                    = OrbitSync;
         clrMask[PND_ORBIT_SYNC] = 1'b1;
      end else if (pending[PND_CALIB_REQ]) begin
         flag                    = CalibReq;
         clrMask[PND_CALIB_REQ]  = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fast_cmd_encoder.sv
`default_nettype none
// ============================================================================
//  Module  : fast_cmd_encoder
//  Brief   : Collects fast-command requests and serializes one word per frame.
//  Revision: 1.0  initial release
// ============================================================================
module fast_cmd_encoder
   import fast_cmd_pkg::*;
#(
   parameter int DROP_CNT_W     = 8,
   parameter bit L1A_FULL_FIRST = 1'b0
) (
   input  logic                  Clk_320_TS,
   input  logic                  n_rstExt,
   input  logic                  enable,
   input  logic                  req_orbit_sync,
   input  logic                  req_l1a_normal,
   input  logic                  req_l1a_full,
   input  logic                  req_orbit_count_reset,
   input  logic                  req_calib_req,
   input  logic                  req_calib_l1a,
   input  logic                  req_resync,
   output logic                  cmd_tx,
   output logic                  clk40_tx,
   output logic                  frame_start,
   output logic [7:0]            word_sent,
   output logic [6:0]            pending,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   logic [2:0]            r_phase;
   logic [7:0]            r_shreg;
   logic [7:0]            r_wordSent;
   pending_t              r_pending;
   logic [DROP_CNT_W-1:0] r_dropCnt;

   pending_t              w_req;
   pending_t              w_selClr;
   pending_t              w_clr;
   pending_t              w_drop;
   logic [3:0]            w_selFlag;
   logic                  w_load;
   logic [DROP_CNT_W+2:0] w_dropSum;
   logic [DROP_CNT_W-1:0] w_dropNext;

   assign w_req = {req_resync, req_orbit_count_reset, req_calib_l1a, req_calib_req,
                   req_l1a_full, req_l1a_normal, req_orbit_sync};

   fast_cmd_word_sel #(
      .L1A_FULL_FIRST (L1A_FULL_FIRST)
   ) u_wordSel (
      .pending (r_pending),
      .enable  (enable),
      .flag    (w_selFlag),
      .clrMask (w_selClr)
   );

   assign w_load = (r_phase == 3'd7);
   assign w_clr  = w_load ? w_selClr : '0;
   // A strobe landing on a flag that is cleared this same edge re-arms it, so it is not a drop.
   assign w_drop = w_req & r_pending & ~w_clr;

   assign w_dropSum  = {3'b000, r_dropCnt} + {{DROP_CNT_W{1'b0}}, countOnes(w_drop)};
   assign w_dropNext = (|w_dropSum[DROP_CNT_W+2:DROP_CNT_W]) ? {DROP_CNT_W{1'b1}}
                                                             : w_dropSum[DROP_CNT_W-1:0];

   always_ff @(posedge Clk_320_TS or negedge n_rstExt) begin
      if (!n_rstExt) begin
         r_phase    <= 3'd0;
         r_shreg    <= IDLE_WORD;
         r_wordSent <= IDLE_WORD;
         r_pending  <= '0;
         r_dropCnt  <= '0;
      end else begin
         r_phase   <= r_phase + 3'd1;
         r_pending <= (r_pending & ~w_clr) | w_req;
         r_dropCnt <= w_dropNext;
         if (w_load) begin
            r_shreg    <= {HEADER, w_selFlag, 1'b1};
            r_wordSent <= {HEADER, w_selFlag, 1'b1};
         end else begin
            r_shreg    <= {r_shreg[6:0], 1'b0};
         end
      end
   end

   assign cmd_tx      = r_shreg[7];
   assign clk40_tx    = ~r_phase[2];
   assign frame_start = (r_phase == 3'd0);
   assign word_sent   = r_wordSent;
   assign pending     = r_pending;
   assign drop_cnt    = r_dropCnt;

endmodule
`default_nettype wire

// File: tb/tb_fast_cmd_encoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fast_cmd_encoder
//  Brief   : Self-checking bench for fast_cmd_encoder.
//  Revision: 1.0  initial release
// ============================================================================
module tb_fast_cmd_encoder;

   localparam logic [6:0] OS  = 7'b0000001;
   localparam logic [6:0] N   = 7'b0000010;
   localparam logic [6:0] F   = 7'b0000100;
   localparam logic [6:0] CR  = 7'b0001000;
   localparam logic [6:0] CL  = 7'b0010000;
   localparam logic [6:0] OCR = 7'b0100000;
   localparam logic [6:0] RS  = 7'b1000000;
   localparam int         NV  = 24;

   typedef struct {
      logic       en;
      logic [6:0] reqA;
      int         phA;
      logic [6:0] reqB;
      int         phB;
      logic [7:0] expWord;
      logic [6:0] expPend;
      int         expDrop;
   } vec_t;

   logic       Clk_320_TS = 1'b0;
   logic       n_rstExt   = 1'b0;
   logic       enable     = 1'b1;
   logic [6:0] req        = '0;
   logic       cmd_tx, clk40_tx, frame_start;
   logic [7:0] word_sent;
   logic [6:0] pending;
   logic [7:0] drop_cnt;

   int         nChecks = 0;
   int         nErrors = 0;
   logic [7:0] lastExp = 8'hC1;
   logic [7:0] expQ[$];
   vec_t       vecs[NV];
   vec_t       post;

   always #5 Clk_320_TS = ~Clk_320_TS;

   fast_cmd_encoder #(
      .DROP_CNT_W     (8),
      .L1A_FULL_FIRST (1'b0)
   ) dut (
      .Clk_320_TS            (Clk_320_TS),
      .n_rstExt              (n_rstExt),
      .enable                (enable),
      .req_orbit_sync        (req[0]),
      .req_l1a_normal        (req[1]),
      .req_l1a_full          (req[2]),
      .req_calib_req         (req[3]),
      .req_calib_l1a         (req[4]),
      .req_orbit_count_reset (req[5]),
      .req_resync            (req[6]),
      .cmd_tx                (cmd_tx),
      .clk40_tx              (clk40_tx),
      .frame_start           (frame_start),
      .word_sent             (word_sent),
      .pending               (pending),
      .drop_cnt              (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clk_320_TS);
   endtask

   // Runs one frame from phase 0, then checks the word loaded at its end.
   task automatic runFrame(input vec_t v, input string tag);
      logic [7:0] expWord;
      expQ.push_back(v.expWord);
      for (int p = 0; p < 8; p++) begin
         enable = v.en;
         req    = ((p == v.phA) ? v.reqA : 7'd0) | ((p == v.phB) ? v.reqB : 7'd0);
         check($sformatf("%s_cmd_tx_p%0d", tag, p), {31'd0, cmd_tx}, {31'd0, lastExp[7-p]});
         check($sformatf("%s_clk40_p%0d", tag, p), {31'd0, clk40_tx}, (p < 4) ? 32'd1 : 32'd0);
         check($sformatf("%s_fstart_p%0d", tag, p), {31'd0, frame_start}, (p == 0) ? 32'd1 : 32'd0);
         tick();
      end
      req = '0;
      if (expQ.size() == 0) begin
         nChecks++;
         nErrors++;
         $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
         expWord = 8'hC1;
      end else begin
         expWord = expQ.pop_front();
      end
      check({tag, "_word"}, {24'd0, word_sent}, {24'd0, expWord});
      check({tag, "_pend"}, {25'd0, pending}, {25'd0, v.expPend});
      check({tag, "_drop"}, {24'd0, drop_cnt}, v.expDrop);
      lastExp = expWord;
   endtask

   initial begin
      //          en    reqA    phA reqB  phB  word   pend  drop
      vecs[0]  = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC1, 7'd0, 0};
      vecs[1]  = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC1, 7'd0, 0};
      vecs[2]  = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC1, 7'd0, 0};
      vecs[3]  = '{1'b1, N,      2, 7'd0, -1, 8'hC5, 7'd0, 0};
      vecs[4]  = '{1'b1, OS | F, 3, 7'd0, -1, 8'hCB, 7'd0, 0};
      vecs[5]  = '{1'b1, RS,     1, F,     5, 8'hD7, 7'd0, 0};
      vecs[6]  = '{1'b1, RS,     0, 7'd0, -1, 8'hDF, 7'd0, 0};
      vecs[7]  = '{1'b1, N,      7, 7'd0, -1, 8'hC1, N,    0};
      vecs[8]  = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC5, 7'd0, 0};
      vecs[9]  = '{1'b1, N,      1, N,     4, 8'hC5, 7'd0, 1};
      vecs[10] = '{1'b0, CR,     2, 7'd0, -1, 8'hC1, CR,   1};
      vecs[11] = '{1'b0, 7'd0,   0, 7'd0, -1, 8'hC1, CR,   1};
      vecs[12] = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hD1, 7'd0, 1};
      vecs[13] = '{1'b1, OCR|OS, 0, 7'd0, -1, 8'hCF, 7'd0, 1};
      vecs[14] = '{1'b1, CL,     0, F,     3, 8'hD5, 7'd0, 1};
      vecs[15] = '{1'b1, CL,     0, 7'd0, -1, 8'hC1, CL,   1};
      vecs[16] = '{1'b1, N | OS, 2, 7'd0, -1, 8'hD3, OS,   1};
      vecs[17] = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC3, 7'd0, 1};
      vecs[18] = '{1'b1, N | F,  1, 7'd0, -1, 8'hC5, F,    1};
      vecs[19] = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC9, 7'd0, 1};
      vecs[20] = '{1'b1, RS | N, 0, 7'd0, -1, 8'hDF, N,    1};
      vecs[21] = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC5, 7'd0, 1};
      vecs[22] = '{1'b1, N,      2, N,     7, 8'hC5, N,    1};
      vecs[23] = '{1'b1, 7'd0,   0, 7'd0, -1, 8'hC5, 7'd0, 1};

      // Reset state
      tick();
      tick();
      check("rst_cmd_tx", {31'd0, cmd_tx}, 32'd1);
      check("rst_clk40", {31'd0, clk40_tx}, 32'd1);
      check("rst_fstart", {31'd0, frame_start}, 32'd1);
      check("rst_word", {24'd0, word_sent}, 32'hC1);
      check("rst_pend", {25'd0, pending}, 32'd0);
      check("rst_drop", {24'd0, drop_cnt}, 32'd0);
      n_rstExt = 1'b1;

      for (int i = 0; i < NV; i++) runFrame(vecs[i], $sformatf("v%0d", i));

      // Drop counter: multi-strobe adds, then saturation with enable held low
      enable = 1'b0;
      req = N | F | CR;
      tick();
      tick();
      req = '0;
      check("drop_multi", {24'd0, drop_cnt}, 32'd4);
      check("drop_pend", {25'd0, pending}, {25'd0, N | F | CR});
      req = N;
      for (int i = 0; i < 250; i++) tick();
      req = '0;
      check("drop_254", {24'd0, drop_cnt}, 32'd254);
      req = N | F | CR;
      tick();
      req = '0;
      check("drop_sat_multi", {24'd0, drop_cnt}, 32'd255);
      req = N;
      for (int i = 0; i < 50; i++) tick();
      req = '0;
      check("drop_sat_hold", {24'd0, drop_cnt}, 32'd255);

      // Mid-frame asynchronous reset
      enable = 1'b1;
      req = RS;
      tick();
      req = '0;
      tick();
      tick();
      #2 n_rstExt = 1'b0;
      #1;
      check("mrst_cmd_tx", {31'd0, cmd_tx}, 32'd1);
      check("mrst_fstart", {31'd0, frame_start}, 32'd1);
      check("mrst_clk40", {31'd0, clk40_tx}, 32'd1);
      check("mrst_word", {24'd0, word_sent}, 32'hC1);
      check("mrst_pend", {25'd0, pending}, 32'd0);
      check("mrst_drop", {24'd0, drop_cnt}, 32'd0);
      tick();
      n_rstExt = 1'b1;
      lastExp  = 8'hC1;
      post     = '{1'b1, 7'd0, 0, 7'd0, -1, 8'hC1, 7'd0, 0};
      runFrame(post, "post_rst");

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
